// File: rtl/nand_chain_sequencer_if.sv
// Bundle between the lab top / gate chain and the NAND chain sequencer.
// slave = sequencer side, master = environment driving start and chain outputs.
interface nand_chain_sequencer_if;
  logic       start;
  logic [3:0] vec_out;
  logic       dut_e;
  logic       dut_f;
  logic       dut_g;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] fail_cnt;
  logic [3:0] first_fail_vec;
  logic       first_fail_valid;

  modport slave (
    input  start, dut_e, dut_f, dut_g,
    output vec_out, busy, done, pass, fail_cnt, first_fail_vec, first_fail_valid
  );

  modport master (
    output start, dut_e, dut_f, dut_g,
    input  vec_out, busy, done, pass, fail_cnt, first_fail_vec, first_fail_valid
  );
endinterface

// File: rtl/nand_chain_sequencer.sv
// Sweeps all 16 {a,b,c,d} vectors through the NAND chain, checks e/f/g against a
// reference, and reports pass/fail. NAND_SEQ_STOP_ON_FAIL_EN ends a run at the first mismatch.
module nand_chain_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  nand_chain_sequencer_if.slave  io_seq
);

  localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  typedef struct packed {
    logic       pass;
    logic [4:0] fail_cnt;
    logic [3:0] ff_vec;
    logic       ff_valid;
  } res_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_vec, w_vec_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  res_t       r_res, w_res_nxt;

  logic       w_exp_e, w_exp_f, w_exp_g;
  logic       w_mismatch;
  logic       w_last;

  // Reference chain evaluated on the registered stimulus.
  assign w_exp_e    = ~(r_vec[3] & r_vec[2]);
  assign w_exp_f    = ~(r_vec[1] & w_exp_e);
  assign w_exp_g    = ~(r_vec[0] & w_exp_f);
  assign w_mismatch = ({io_seq.dut_e, io_seq.dut_f, io_seq.dut_g} != {w_exp_e, w_exp_f, w_exp_g});

`ifdef NAND_SEQ_STOP_ON_FAIL_EN
  assign w_last = (r_vec == 4'd15) || w_mismatch;
`else
  assign w_last = (r_vec == 4'd15);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec;
    w_cnt_nxt   = r_cnt;
    w_res_nxt   = r_res;
    case (r_state)
      S_IDLE: begin
        if (io_seq.start) begin
          w_state_nxt = S_SETTLE;
          w_vec_nxt   = 4'd0;
          w_cnt_nxt   = RELOAD;
          w_res_nxt   = '0;
        end
      end
      S_SETTLE: begin
        if (r_cnt == 4'd0) w_state_nxt = S_CHECK;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      S_CHECK: begin
        // One failing vector counts once regardless of how many outputs differ.
        if (w_mismatch) begin
          w_res_nxt.fail_cnt = r_res.fail_cnt + 5'd1;
          if (!r_res.ff_valid) begin
            w_res_nxt.ff_vec   = r_vec;
            w_res_nxt.ff_valid = 1'b1;
          end
        end
        if (w_last) begin
          w_state_nxt    = S_DONE;
          w_res_nxt.pass = (w_res_nxt.fail_cnt == 5'd0);
        end else begin
          w_state_nxt = S_SETTLE;
          w_vec_nxt   = r_vec + 4'd1;
          w_cnt_nxt   = RELOAD;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec <= 4'd0;
      r_cnt <= 4'd0;
      r_res <= '0;
    end else begin
      r_vec <= w_vec_nxt;
      r_cnt <= w_cnt_nxt;
      r_res <= w_res_nxt;
    end
  end

  assign io_seq.vec_out          = r_vec;
  assign io_seq.busy             = (r_state == S_SETTLE) || (r_state == S_CHECK);
  assign io_seq.done             = (r_state == S_DONE);
  assign io_seq.pass             = r_res.pass;
  assign io_seq.fail_cnt         = r_res.fail_cnt;
  assign io_seq.first_fail_vec   = r_res.ff_vec;
  assign io_seq.first_fail_valid = r_res.ff_valid;

endmodule

// File: tb/tb_nand_chain_sequencer.sv
// Bench for nand_chain_sequencer: a faultable chain model drives dut_e/f/g and
// expected run results come from sweeping the 16 vectors in plain loops.
module tb_nand_chain_sequencer;

  localparam int SC = 2;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;

  logic [2:0]        stk_en;
  logic [2:0]        stk_val;
  logic [15:0][2:0]  xmask;
  logic [2:0]        w_gold;
  logic [2:0]        w_drv;

  nand_chain_sequencer_if bus();

  nand_chain_sequencer #(.SETTLE_CYCLES(SC)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_seq (bus.slave)
  );

  function automatic logic [2:0] golden(input logic [3:0] v);
    logic e, f, g;
    e = ~(v[3] & v[2]);
    f = ~(v[1] & e);
    g = ~(v[0] & f);
    return {e, f, g};
  endfunction

  assign w_gold    = golden(bus.vec_out);
  assign w_drv     = ((w_gold & ~stk_en) | (stk_val & stk_en)) ^ xmask[bus.vec_out];
  assign bus.dut_e = w_drv[2];
  assign bus.dut_f = w_drv[1];
  assign bus.dut_g = w_drv[0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected run outcome from the current fault setup.
  task automatic model(output int cnt, output int ff, output bit ffv);
    logic [2:0] g, d;
    cnt = 0; ff = 0; ffv = 1'b0;
    for (int v = 0; v < 16; v++) begin
      g = golden(4'(v));
      d = ((g & ~stk_en) | (stk_val & stk_en)) ^ xmask[v];
      if (d != g) begin
        if (!ffv) begin ffv = 1'b1; ff = v; end
        cnt++;
`ifdef NAND_SEQ_STOP_ON_FAIL_EN
        break;
`endif
      end
    end
  endtask

  task automatic run_check(input string nm, input int e_fail, input int e_ffv,
                           input bit e_ffval, input bit hold, output int t);
    int nvec, e_done;
    @(negedge clk); bus.start = 1'b1; t = cyc;
    @(negedge clk); if (!hold) bus.start = 1'b0;
    nvec = 16;
`ifdef NAND_SEQ_STOP_ON_FAIL_EN
    if (e_ffval) nvec = e_ffv + 1;
`endif
    e_done = t + 1 + nvec * (SC + 1);
    total++;
    if (bus.vec_out !== 4'd0 || bus.busy !== 1'b1 || bus.fail_cnt !== 5'd0 ||
        bus.first_fail_valid !== 1'b0 || bus.pass !== 1'b0 || bus.first_fail_vec !== 4'd0) begin
      bad++;
      $display("FAIL %s_accept: vec=%0d busy=%0b fail=%0d ffval=%0b ffv=%0d pass=%0b want 0/1/0/0/0/0",
               nm, bus.vec_out, bus.busy, bus.fail_cnt, bus.first_fail_valid, bus.first_fail_vec, bus.pass);
    end
    while (bus.done !== 1'b1 && cyc < t + 400) begin
      total++;
      if (bus.busy !== 1'b1 || bus.vec_out !== 4'((cyc - t - 1) / (SC + 1))) begin
        bad++;
        $display("FAIL %s_sweep: cycle=%0d busy=%0b vec=%0d want busy=1 vec=%0d",
                 nm, cyc - t, bus.busy, bus.vec_out, (cyc - t - 1) / (SC + 1));
      end
      @(negedge clk);
    end
    total++;
    if (bus.done !== 1'b1) begin
      bad++;
      $display("FAIL %s_timeout: done never rose, want cycle %0d", nm, e_done - t);
      return;
    end
    total++;
    if (cyc != e_done) begin
      bad++; $display("FAIL %s_done_cycle: got T+%0d want T+%0d", nm, cyc - t, e_done - t);
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL %s_busy_in_done: got %0b want 0", nm, bus.busy);
    end
    total++;
    if (bus.fail_cnt !== 5'(e_fail) || bus.pass !== (e_fail == 0) || bus.first_fail_valid !== e_ffval) begin
      bad++;
      $display("FAIL %s_result: fail=%0d pass=%0b ffval=%0b want %0d/%0b/%0b",
               nm, bus.fail_cnt, bus.pass, bus.first_fail_valid, e_fail, e_fail == 0, e_ffval);
    end
    if (e_ffval) begin
      total++;
      if (bus.first_fail_vec !== 4'(e_ffv)) begin
        bad++; $display("FAIL %s_first_vec: got %0d want %0d", nm, bus.first_fail_vec, e_ffv);
      end
    end
    @(negedge clk);
    total++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.fail_cnt !== 5'(e_fail) || bus.pass !== (e_fail == 0)) begin
      bad++;
      $display("FAIL %s_after_done: done=%0b busy=%0b fail=%0d pass=%0b want 0/0/%0d/%0b",
               nm, bus.done, bus.busy, bus.fail_cnt, bus.pass, e_fail, e_fail == 0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.vec_out !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.pass !== 1'b0 ||
        bus.fail_cnt !== 5'd0 || bus.first_fail_vec !== 4'd0 || bus.first_fail_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: vec=%0d busy=%0b done=%0b pass=%0b fail=%0d ffv=%0d ffval=%0b want all 0",
               bus.vec_out, bus.busy, bus.done, bus.pass, bus.fail_cnt, bus.first_fail_vec, bus.first_fail_valid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_golden();
    int t;
    run_check("golden", 0, 0, 1'b0, 1'b0, t);
  endtask

  task automatic test_stuck_e();
    int t;
    stk_en = 3'b100; stk_val = 3'b100;
`ifdef NAND_SEQ_STOP_ON_FAIL_EN
    run_check("stuck_e1", 1, 12, 1'b1, 1'b0, t);
`else
    run_check("stuck_e1", 4, 12, 1'b1, 1'b0, t);
`endif
    stk_en = 3'b000; stk_val = 3'b000;
  endtask

  task automatic test_stuck_g();
    int t;
    stk_en = 3'b001; stk_val = 3'b000;
`ifdef NAND_SEQ_STOP_ON_FAIL_EN
    run_check("stuck_g0", 1, 0, 1'b1, 1'b0, t);
`else
    run_check("stuck_g0", 11, 0, 1'b1, 1'b0, t);
`endif
    stk_en = 3'b000;
  endtask

  task automatic test_random();
    int t, cnt, ff;
    bit ffv;
    for (int r = 0; r < 8; r++) begin
      for (int v = 0; v < 16; v++)
        xmask[v] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      model(cnt, ff, ffv);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_check("random", cnt, ff, ffv, 1'b0, t);
    end
    xmask = '0;
  endtask

  task automatic test_back_to_back();
    int t, t2;
    stk_en = 3'b100; stk_val = 3'b100;
`ifdef NAND_SEQ_STOP_ON_FAIL_EN
    run_check("b2b_first", 1, 12, 1'b1, 1'b1, t);
`else
    run_check("b2b_first", 4, 12, 1'b1, 1'b1, t);
`endif
    stk_en = 3'b000; stk_val = 3'b000;
    t2 = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    total++;
    if (bus.busy !== 1'b1 || bus.vec_out !== 4'd0 || bus.fail_cnt !== 5'd0 ||
        bus.first_fail_valid !== 1'b0 || bus.pass !== 1'b0) begin
      bad++;
      $display("FAIL b2b_second_accept: busy=%0b vec=%0d fail=%0d ffval=%0b pass=%0b want 1/0/0/0/0",
               bus.busy, bus.vec_out, bus.fail_cnt, bus.first_fail_valid, bus.pass);
    end
    while (bus.done !== 1'b1 && cyc < t2 + 400) @(negedge clk);
    total++;
    if (bus.done !== 1'b1 || cyc != t2 + 1 + 16 * (SC + 1) || bus.pass !== 1'b1 || bus.fail_cnt !== 5'd0) begin
      bad++;
      $display("FAIL b2b_second_done: done=%0b at T+%0d pass=%0b fail=%0d want 1 at T+%0d pass=1 fail=0",
               bus.done, cyc - t2, bus.pass, bus.fail_cnt, 1 + 16 * (SC + 1));
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int t;
    xmask = '0;
    xmask[3] = 3'b001;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    for (int i = 0; i < 100 && bus.vec_out !== 4'd7; i++) @(negedge clk);
    total++;
    if (bus.vec_out !== 4'd7 || bus.fail_cnt !== 5'd1) begin
      bad++; $display("FAIL midrun_reach_v7: vec=%0d fail=%0d want 7/1", bus.vec_out, bus.fail_cnt);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.vec_out !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.pass !== 1'b0 ||
        bus.fail_cnt !== 5'd0 || bus.first_fail_vec !== 4'd0 || bus.first_fail_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrun_async_reset: vec=%0d busy=%0b done=%0b pass=%0b fail=%0d ffv=%0d ffval=%0b want all 0",
               bus.vec_out, bus.busy, bus.done, bus.pass, bus.fail_cnt, bus.first_fail_vec, bus.first_fail_valid);
    end
    xmask = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        bad++; $display("FAIL midrun_no_done: done=%0b busy=%0b want 0/0", bus.done, bus.busy);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL midrun_after_release: done=%0b busy=%0b want 0/0", bus.done, bus.busy);
    end
    run_check("after_reset", 0, 0, 1'b0, 1'b0, t);
  endtask

  initial begin
    total = 0; bad = 0;
    bus.start = 1'b0;
    stk_en = 3'b000; stk_val = 3'b000;
    xmask = '0;
    test_reset();
    test_golden();
    test_stuck_e();
    test_stuck_g();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
